// File: rtl/relu_grad_gate.sv
// relu_grad_gate
//   Backward-pass gradient gate for the pipelined ReLU activation unit.
//   The forward pass records one mask bit per activation (1 when x > 0)
//   into a small FIFO. The backward pass pops those bits in the same order
//   and either passes the upstream gradient through or forces it to +0.0.
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   fwd_valid/ready/x     : forward activation stream (mask writer side)
//   bwd_valid/ready/grad  : upstream gradient stream dL/dy
//   out_valid/ready/grad  : gated gradient stream dL/dx (registered, 1 cycle)
//   mask_count            : number of mask bits currently held (0..DEPTH)
//   flush                 : synchronous clear of FIFO and output register
module relu_grad_gate #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fwd_valid,
  output logic              fwd_ready,
  input  logic [DATA_W-1:0] fwd_x,
  input  logic              bwd_valid,
  output logic              bwd_ready,
  input  logic [DATA_W-1:0] bwd_grad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_grad,
  output logic [CNT_W-1:0]  mask_count,
  input  logic              flush
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mask_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             fwd_mask;
  logic             rd_mask;

  // Strictly positive: sign clear and not +0.0. +Inf and +NaN count as
  // positive, every negative encoding (including -NaN) does not.
  assign fwd_mask = ~fwd_x[DATA_W-1] & (|fwd_x[DATA_W-2:0]);

  // fwd_ready looks only at occupancy, so a full FIFO refuses a push even
  // when a pop happens in the same cycle. bwd_ready never bypasses an empty
  // FIFO and stalls while the output register is holding an unaccepted word.
  assign fwd_ready = (mask_count != CNT_W'(DEPTH));
  assign bwd_ready = (mask_count != '0) & (~out_valid | out_ready);

  // flush wins over both handshakes.
  assign push = fwd_valid & fwd_ready & ~flush;
  assign pop  = bwd_valid & bwd_ready & ~flush;

  assign rd_mask = mask_mem[rd_ptr];

  // Mask storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr] <= fwd_mask;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mask_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mask_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   mask_count <= mask_count + CNT_W'(1);
        2'b01:   mask_count <= mask_count - CNT_W'(1);
        default: mask_count <= mask_count;
      endcase
    end
  end

  // Output register: a pop loads the gated gradient; otherwise an accepted
  // word retires and out_grad keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_grad  <= rd_mask ? bwd_grad : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_grad_gate.sv
// tb_relu_grad_gate
//   Self-checking bench for relu_grad_gate. A queue-based reference model
//   tracks the mask FIFO and output register; a compare process checks every
//   cycle, and directed sequences pin the model with literal expectations.
module tb_relu_grad_gate;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [31:0] fwd_x;
  logic        bwd_valid;
  logic        bwd_ready;
  logic [31:0] bwd_grad;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_grad;
  logic [4:0]  mask_count;
  logic        flush;

  int checks;
  int failures;

  relu_grad_gate #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_x(fwd_x),
    .bwd_valid(bwd_valid), .bwd_ready(bwd_ready), .bwd_grad(bwd_grad),
    .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad),
    .mask_count(mask_count), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO is a queue of bits, the output a value/flag.
  bit          model_q[$];
  bit          model_valid;
  logic [31:0] model_grad;

  function automatic bit positive(input logic [31:0] x);
    return (x[31] == 1'b0) && (x != 32'h0);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit f_rdy, b_rdy, m;
    if (!rst_n) begin
      model_q.delete();
      model_valid = 1'b0;
      model_grad  = 32'h0;
    end else if (flush) begin
      model_q.delete();
      model_valid = 1'b0;
      model_grad  = 32'h0;
    end else begin
      f_rdy = (model_q.size() != DEPTH);
      b_rdy = (model_q.size() != 0) && (!model_valid || out_ready);
      if (bwd_valid && b_rdy) begin
        m = model_q.pop_front();
        model_grad  = m ? bwd_grad : 32'h0;
        model_valid = 1'b1;
      end else if (out_ready) begin
        model_valid = 1'b0;
      end
      if (fwd_valid && f_rdy) model_q.push_back(positive(fwd_x));
    end
  end

  // Per-cycle comparison, well after the edge and before inputs change.
  always @(posedge clk) begin
    #2;
    check_output("cyc_fwd_ready", 32'(fwd_ready), 32'(model_q.size() != DEPTH));
    check_output("cyc_bwd_ready", 32'(bwd_ready),
                 32'((model_q.size() != 0) && (!model_valid || out_ready)));
    check_output("cyc_mask_count", 32'(mask_count), 32'(model_q.size()));
    check_output("cyc_out_valid", 32'(out_valid), 32'(model_valid));
    if (model_valid) check_output("cyc_out_grad", out_grad, model_grad);
  end

  task automatic apply_stimulus(input logic fv, input logic [31:0] fx, input logic bv,
                                input logic [31:0] bg, input logic ordy, input logic fl);
    @(negedge clk);
    fwd_valid = fv; fwd_x = fx; bwd_valid = bv; bwd_grad = bg;
    out_ready = ordy; flush = fl;
    @(posedge clk);
    #3;
  endtask

  logic [31:0] seq_x   [6] = '{32'h3dcccccd, 32'hfdcccccd, 32'h3ddccccd,
                               32'hfccccccd, 32'h00000000, 32'h80000000};
  logic [31:0] seq_exp [6] = '{32'h3f800000, 32'h0, 32'h3f800000, 32'h0, 32'h0, 32'h0};
  logic [31:0] special [4] = '{32'h7f800000, 32'hffc00000, 32'h7fc00000, 32'hff800000};

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; fwd_valid = 1'b0; fwd_x = '0; bwd_valid = 1'b0;
    bwd_grad = '0; out_ready = 1'b1; flush = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #3;
    check_output("rst_out_grad", out_grad, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 0, 1, 0);
    check_output("idle_fwd_ready", 32'(fwd_ready), 32'd1);
    check_output("idle_bwd_ready", 32'(bwd_ready), 32'd0);
    check_output("idle_out_valid", 32'(out_valid), 32'd0);
    check_output("idle_mask_count", 32'(mask_count), 32'd0);

    // Mask rule sequence with literal gated outputs
    foreach (seq_x[i]) apply_stimulus(1, seq_x[i], 0, 0, 1, 0);
    check_output("seq_count", 32'(mask_count), 32'd6);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 1, 32'h3f800000, 1, 0);
      check_output("seq_valid", 32'(out_valid), 32'd1);
      check_output("seq_grad", out_grad, seq_exp[i]);
    end
    apply_stimulus(0, 0, 0, 0, 1, 0);
    check_output("seq_drained", 32'(out_valid), 32'd0);

    // Fill to DEPTH, including special encodings
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(1, (i < 4) ? special[i] : $urandom, 0, 0, 1, 0);
    check_output("full_count", 32'(mask_count), 32'd16);
    check_output("full_fwd_ready", 32'(fwd_ready), 32'd0);
    apply_stimulus(1, 32'h3f800000, 0, 0, 1, 0);
    check_output("refused_count", 32'(mask_count), 32'd16);
    apply_stimulus(0, 0, 1, 32'h40000000, 1, 0);
    check_output("pop_fwd_ready", 32'(fwd_ready), 32'd1);
    check_output("pop_count", 32'(mask_count), 32'd15);
    check_output("pop_grad_inf", out_grad, 32'h40000000);

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 1, $urandom, 0, 0);
      check_output("bp_bwd_ready", 32'(bwd_ready), 32'd0);
      check_output("bp_count", 32'(mask_count), 32'd15);
      check_output("bp_grad", out_grad, 32'h40000000);
    end
    begin
      int n = 0;
      while (model_q.size() != 0 && n < 40) begin
        apply_stimulus(0, 0, 1, $urandom, 1, 0);
        n++;
      end
      check_output("drain_cycles", 32'(n), 32'd15);
    end
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Concurrent push/pop at occupancy 8
    for (int i = 0; i < 8; i++) apply_stimulus(1, $urandom, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, $urandom, 1, $urandom, 1, 0);
      check_output("conc_count", 32'(mask_count), 32'd8);
    end

    // Flush at occupancy 5 with a valid output
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, $urandom, 1, 0);
    check_output("preflush_count", 32'(mask_count), 32'd5);
    check_output("preflush_valid", 32'(out_valid), 32'd1);
    apply_stimulus(1, 32'h3f800000, 1, 32'h3f800000, 1, 1);
    check_output("flush_count", 32'(mask_count), 32'd0);
    check_output("flush_valid", 32'(out_valid), 32'd0);
    check_output("flush_bwd_ready", 32'(bwd_ready), 32'd0);
    check_output("flush_grad", out_grad, 32'h0);
    apply_stimulus(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) apply_stimulus(1, 32'h3f800000, 0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 32'h12345678, 0, 0);
    check_output("prerst_grad", out_grad, 32'h12345678);
    @(negedge clk);
    bwd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_count", 32'(mask_count), 32'd0);
    check_output("arst_valid", 32'(out_valid), 32'd0);
    check_output("arst_fwd_ready", 32'(fwd_ready), 32'd1);
    check_output("arst_bwd_ready", 32'(bwd_ready), 32'd0);
    check_output("arst_grad", out_grad, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) apply_stimulus(0, 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
- Backward-pass companion to the pipelined ReLU activation unit for the super-resolution datapath.
- During the forward pass it records one mask bit per IEEE-754 single-precision activation input: 1 when x > 0.
- During the backward pass it reads those bits back in FIFO order and gates the incoming gradient stream: the gradient passes through when the mask bit is 1 and is forced to +0.0 when it is 0.
- It is the reader side of the activation-mask interface that the forward ReLU path writes.

Parameters:
- DATA_W, 32, width of activation and gradient words (IEEE-754 single precision; bit DATA_W-1 is the sign).
- DEPTH, 16, mask FIFO depth in entries; must be a power of two, at least 2.
- CNT_W, 5, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fwd_valid  in  1  forward activation x is presented.
- fwd_ready  out  1  mask FIFO can accept an entry.
- fwd_x  in  DATA_W  forward-pass ReLU input x.
- bwd_valid  in  1  upstream gradient is presented.
- bwd_ready  out  1  gradient is accepted this cycle.
- bwd_grad  in  DATA_W  upstream gradient dL/dy.
- out_valid  out  1  gated gradient is valid.
- out_ready  in  1  downstream accepts the gated gradient.
- out_grad  out  DATA_W  gated gradient dL/dx.
- mask_count  out  CNT_W  number of mask bits held (0..DEPTH).
- flush  in  1  synchronous clear of the FIFO and output register.

Behaviour:
- Reset (rst_n low, asynchronous): read pointer = 0, write pointer = 0, mask_count = 0, out_valid = 0, out_grad = 0. The mask storage itself is not reset. Consequently fwd_ready = 1 and bwd_ready = 0 while in reset.
- Mask rule: mask = ~fwd_x[31] & (|fwd_x[30:0]).
  - +0.0 and -0.0 give 0.
  - Any negative value, including -NaN, gives 0.
  - +Inf and +NaN give 1.
- Forward write:
  - fwd_ready = (mask_count != DEPTH). It is combinational and does not depend on a same-cycle pop.
  - fwd_valid & fwd_ready pushes the mask bit at the write pointer, then advances the pointer (wraps modulo DEPTH).
- Backward read:
  - bwd_ready = (mask_count != 0) & (~out_valid | out_ready).
  - bwd_valid & bwd_ready pops the bit at the read pointer (wraps modulo DEPTH).
  - The output register loads out_grad = mask ? bwd_grad : 32'h00000000 and sets out_valid = 1 on the next clk edge.
  - Latency from acceptance to output is exactly 1 cycle.
  - Full throughput of 1 word/cycle is sustained while out_ready = 1 and the FIFO is non-empty.
- Output handshake:
  - out_valid & out_ready with no new acceptance clears out_valid the next cycle.
  - out_valid & ~out_ready holds out_grad and out_valid stable; bwd_ready = 0.
- Simultaneous push and pop: mask_count is unchanged and both pointers advance.
  - On an empty FIFO, a pop is impossible in that cycle: no bypass, bwd_ready = 0.
  - On a full FIFO, the push is refused in that cycle.
- flush (synchronous, highest priority over push and pop): pointers = 0, mask_count = 0, out_valid = 0, out_grad = 0, and any same-cycle handshakes are ignored.
- Reset asserted mid-stream discards all pending masks and any in-flight output immediately.
- mask_count updates on the same clk edge as the push or pop.

Test Plan:
- Reset then idle: rst_n = 0 for 3 cycles, then released → fwd_ready = 1, bwd_ready = 0, out_valid = 0, mask_count = 0.
- Push fwd_x = 3dcccccd, fdcccccd, 3ddccccd, fccccccd, 00000000, 80000000, then feed bwd_grad = 3f800000 six times with out_ready = 1 → out_grad sequence 3f800000, 0, 3f800000, 0, 0, 0, each 1 cycle after acceptance.
- Fill with DEPTH = 16 pushes → mask_count = 16, fwd_ready = 0. A 17th fwd_valid is refused. One pop → fwd_ready = 1 next cycle.
- Backpressure: out_ready = 0 with out_valid = 1 for 4 cycles → out_grad stable, bwd_ready = 0, mask_count unchanged. Releasing out_ready → the stream resumes at 1/cycle with no lost or duplicated words.
- Concurrent push and pop at mask_count = 8 for 20 cycles → mask_count stays 8, pointer wrap past 15 is correct, and the output order matches input order.
- flush asserted while mask_count = 5 and out_valid = 1 → next cycle mask_count = 0, out_valid = 0, bwd_ready = 0.
